// File: rtl/spcpu_fetch_unit.sv
// spcpu_fetch_unit: instruction prefetch unit for the spcpu core.
// Streams halfwords from memory into a small circular queue and assembles
// 16-bit and 32-bit instructions for the decode stage.
//
// Ports:
//   clk          - sole clock, all state updates on posedge
//   reset        - synchronous, active-low
//   fetch_en     - level, permits memory requests
//   mem_req      - read request valid (from registered state only)
//   mem_addr     - halfword-aligned read address
//   mem_ack      - memory accepts request, mem_rdata valid same cycle
//   mem_rdata    - read data
//   redirect     - flush queue and restart fetch at redirect_pc
//   redirect_pc  - new fetch address (bit 0 ignored)
//   instr_valid  - complete instruction at queue head
//   instr_ready  - consumer accepts the head instruction
//   instr_hi     - first (or only) halfword
//   instr_lo     - second halfword, 0 for 16-bit instructions
//   instr_is_32  - head instruction is 32-bit
//   instr_pc     - address of instr_hi
module spcpu_fetch_unit #(
    parameter int unsigned              ADDR_WIDTH    = 16,
    parameter int unsigned              HW_WIDTH      = 16,
    parameter int unsigned              QUEUE_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC      = '0,
    parameter int unsigned              LONG_PREFIX_W = 3,
    parameter logic [LONG_PREFIX_W-1:0] LONG_PREFIX   = 3'b111
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_en,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [HW_WIDTH-1:0]   mem_rdata,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [HW_WIDTH-1:0]   instr_hi,
    output logic [HW_WIDTH-1:0]   instr_lo,
    output logic                  instr_is_32,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [HW_WIDTH-1:0]   q_data [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_addr [QUEUE_DEPTH];
    logic [PTR_W-1:0]      rd_q, wr_q;
    logic [CNT_W-1:0]      count_q;
    logic [ADDR_WIDTH-1:0] fetch_addr_q;

    logic [PTR_W-1:0]      rd_plus1;
    logic                  head_long;
    logic                  has_one;
    logic                  has_two;
    logic                  head_is_32;
    logic                  q_not_full;
    logic                  push;
    logic                  pop;
    logic [CNT_W-1:0]      pop_cnt;
    logic [CNT_W-1:0]      count_next;
    logic [ADDR_WIDTH-1:0] redirect_aligned;

    // Head decode: a long head needs its second halfword queued before it is valid
    assign rd_plus1   = rd_q + PTR_W'(1);
    assign head_long  = (q_data[rd_q][HW_WIDTH-1 -: LONG_PREFIX_W] == LONG_PREFIX);
    assign has_one    = (count_q != '0);
    assign has_two    = (count_q >= CNT_W'(2));
    assign head_is_32 = has_one && head_long;
    assign q_not_full = (count_q < CNT_W'(QUEUE_DEPTH));

    assign instr_valid = has_one && (!head_long || has_two);
    assign instr_hi    = q_data[rd_q];
    assign instr_lo    = head_is_32 ? q_data[rd_plus1] : '0;
    assign instr_is_32 = head_is_32;
    assign instr_pc    = q_addr[rd_q];

    // Request depends only on registered state, never on mem_ack
    assign mem_req  = (state_q == ST_FETCH) && q_not_full;
    assign mem_addr = fetch_addr_q;

    // Redirect voids both the memory transfer and the consumer handshake
    assign push       = mem_req && mem_ack && !redirect;
    assign pop        = instr_valid && instr_ready && !redirect;
    assign pop_cnt    = !pop ? CNT_W'(0) : (head_is_32 ? CNT_W'(2) : CNT_W'(1));
    assign count_next = count_q + CNT_W'(push) - pop_cnt;

    // Masking keeps every redirect_pc bit referenced while forcing alignment
    assign redirect_aligned = redirect_pc & ~ADDR_WIDTH'(1);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = fetch_en ? ST_FETCH : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fetch_en) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!fetch_en) begin
                        state_d = ST_IDLE;
                    end else if (count_next == CNT_W'(QUEUE_DEPTH)) begin
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (!fetch_en) begin
                        state_d = ST_IDLE;
                    end else if (count_next < CNT_W'(QUEUE_DEPTH)) begin
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Queue pointers, count and fetch address
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q         <= '0;
            wr_q         <= '0;
            count_q      <= '0;
            fetch_addr_q <= RESET_PC;
        end else if (redirect) begin
            rd_q         <= '0;
            wr_q         <= '0;
            count_q      <= '0;
            fetch_addr_q <= redirect_aligned;
        end else begin
            if (push) begin
                wr_q         <= wr_q + PTR_W'(1);
                fetch_addr_q <= fetch_addr_q + ADDR_WIDTH'(2);
            end
            if (pop) begin
                // PTR_W'(2) wraps correctly for a two-entry queue
                rd_q <= rd_q + (head_is_32 ? PTR_W'(2) : PTR_W'(1));
            end
            count_q <= count_next;
        end
    end

    // Queue storage: halfword plus its fetch address
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                q_data[PTR_W'(i)] <= '0;
                q_addr[PTR_W'(i)] <= RESET_PC;
            end
        end else if (push) begin
            q_data[wr_q] <= mem_rdata;
            q_addr[wr_q] <= fetch_addr_q;
        end
    end

endmodule

// File: tb/tb_spcpu_fetch_unit.sv
// Directed self-checking bench for spcpu_fetch_unit (default parameters).
// Memory model: each byte address a returns {1'b0, a[15:1]} (never a long
// prefix) unless overridden; inputs change on negedge, outputs checked there.
module tb_spcpu_fetch_unit;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_hi;
    logic [15:0] instr_lo;
    logic        instr_is_32;
    logic [15:0] instr_pc;

    logic [15:0] mem [0:65535];

    int checks;
    int failures;

    spcpu_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_hi    (instr_hi),
        .instr_lo    (instr_lo),
        .instr_is_32 (instr_is_32),
        .instr_pc    (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_mem(input string tag, input logic req, input logic [15:0] addr);
        check({tag, ".mem_req"}, 32'(mem_req), 32'(req));
        check({tag, ".mem_addr"}, 32'(mem_addr), 32'(addr));
    endtask

    task automatic chk_valid(input string tag, input logic v);
        check({tag, ".instr_valid"}, 32'(instr_valid), 32'(v));
    endtask

    task automatic chk_instr(input string tag, input logic v, input logic [15:0] hi,
                             input logic [15:0] lo, input logic is32, input logic [15:0] pc);
        check({tag, ".instr_valid"}, 32'(instr_valid), 32'(v));
        check({tag, ".instr_hi"}, 32'(instr_hi), 32'(hi));
        check({tag, ".instr_lo"}, 32'(instr_lo), 32'(lo));
        check({tag, ".instr_is_32"}, 32'(instr_is_32), 32'(is32));
        check({tag, ".instr_pc"}, 32'(instr_pc), 32'(pc));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int a = 0; a < 65536; a++) begin
            mem[a] = 16'(a >> 1);
        end
        mem[16'h0000] = 16'h1234;
        mem[16'h0002] = 16'h5678;
        mem[16'h0200] = 16'hE001;
        mem[16'h0202] = 16'hBEEF;

        reset       = 1'b0;
        fetch_en    = 1'b1;
        mem_ack     = 1'b1;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;

        // Reset values
        tick();
        tick();
        chk_mem("rst", 1'b0, 16'h0000);
        chk_instr("rst", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

        // Normal fetch: IDLE->FETCH edge, then one transfer per cycle
        reset = 1'b1;
        tick();
        chk_mem("t1_fetch", 1'b1, 16'h0000);
        chk_valid("t1_empty", 1'b0);
        tick();
        chk_mem("t1_a2", 1'b1, 16'h0002);
        chk_instr("t1_i0", 1'b1, 16'h1234, 16'h0000, 1'b0, 16'h0000);
        tick();
        chk_mem("t1_a4", 1'b1, 16'h0004);
        chk_instr("t1_i1", 1'b1, 16'h5678, 16'h0000, 1'b0, 16'h0002);

        // 32-bit assembly with a memory gap between the halves
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        tick();
        redirect = 1'b0;
        chk_mem("t2_redir", 1'b1, 16'h0200);
        chk_valid("t2_empty", 1'b0);
        tick();
        chk_mem("t2_a202", 1'b1, 16'h0202);
        chk_valid("t2_half", 1'b0);
        mem_ack = 1'b0;
        tick();
        chk_mem("t2_hold", 1'b1, 16'h0202);
        chk_valid("t2_gap", 1'b0);
        mem_ack = 1'b1;
        tick();
        chk_instr("t2_long", 1'b1, 16'hE001, 16'hBEEF, 1'b1, 16'h0200);
        tick();
        chk_instr("t2_next", 1'b1, 16'h0102, 16'h0000, 1'b0, 16'h0204);

        // Full queue: exactly four transfers, then one pop re-enables fetch
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0300;
        tick();
        redirect = 1'b0;
        chk_mem("t3_r", 1'b1, 16'h0300);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk_mem("t3_fill", 1'b1, 16'(16'h0300 + 2 * i));
        end
        tick();
        chk_mem("t3_full", 1'b0, 16'h0308);
        chk_instr("t3_head", 1'b1, 16'h0180, 16'h0000, 1'b0, 16'h0300);
        tick();
        chk_mem("t3_hold", 1'b0, 16'h0308);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk_mem("t3_resume", 1'b1, 16'h0308);
        chk_instr("t3_pop", 1'b1, 16'h0181, 16'h0000, 1'b0, 16'h0302);
        tick();
        chk_mem("t3_refull", 1'b0, 16'h030A);

        // Redirect colliding with a transfer and a pop
        instr_ready = 1'b1;
        tick();
        chk_mem("t4_pre", 1'b1, 16'h030A);
        chk_valid("t4_pre", 1'b1);
        redirect    = 1'b1;
        redirect_pc = 16'h0101;
        tick();
        redirect = 1'b0;
        chk_mem("t4_r", 1'b1, 16'h0100);
        chk_valid("t4_empty", 1'b0);
        tick();
        chk_mem("t4_a102", 1'b1, 16'h0102);
        chk_instr("t4_first", 1'b1, 16'h0080, 16'h0000, 1'b0, 16'h0100);

        // Address wrap with memory stalls
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        mem_ack     = 1'b0;
        tick();
        redirect = 1'b0;
        chk_mem("t5_r", 1'b1, 16'hFFFE);
        chk_valid("t5_empty", 1'b0);
        tick();
        chk_mem("t5_gap0", 1'b1, 16'hFFFE);
        mem_ack = 1'b1;
        tick();
        chk_mem("t5_wrap", 1'b1, 16'h0000);
        chk_instr("t5_i0", 1'b1, 16'h7FFF, 16'h0000, 1'b0, 16'hFFFE);
        mem_ack = 1'b0;
        tick();
        chk_mem("t5_gap1", 1'b1, 16'h0000);
        chk_valid("t5_drained", 1'b0);
        tick();
        chk_mem("t5_gap2", 1'b1, 16'h0000);
        mem_ack = 1'b1;
        tick();
        chk_mem("t5_a2", 1'b1, 16'h0002);
        chk_instr("t5_i1", 1'b1, 16'h1234, 16'h0000, 1'b0, 16'h0000);
        tick();
        chk_mem("t5_a4", 1'b1, 16'h0004);
        chk_instr("t5_i2", 1'b1, 16'h5678, 16'h0000, 1'b0, 16'h0002);

        // fetch_en low mid-stream: request drops, queue drains, fetch resumes
        fetch_en    = 1'b0;
        instr_ready = 1'b0;
        tick();
        chk_mem("t6_off", 1'b0, 16'h0006);
        chk_instr("t6_held", 1'b1, 16'h5678, 16'h0000, 1'b0, 16'h0002);
        instr_ready = 1'b1;
        tick();
        chk_mem("t6_idle", 1'b0, 16'h0006);
        chk_instr("t6_drain", 1'b1, 16'h0002, 16'h0000, 1'b0, 16'h0004);
        tick();
        chk_mem("t6_idle2", 1'b0, 16'h0006);
        chk_valid("t6_empty", 1'b0);
        fetch_en = 1'b1;
        tick();
        chk_mem("t6_resume", 1'b1, 16'h0006);
        tick();
        chk_mem("t6_a8", 1'b1, 16'h0008);
        chk_instr("t6_i", 1'b1, 16'h0003, 16'h0000, 1'b0, 16'h0006);

        // Reset asserted mid-operation
        reset = 1'b0;
        tick();
        chk_mem("t7_rst", 1'b0, 16'h0000);
        chk_instr("t7_rst", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spcpu_fetch_unit.md
# spcpu_fetch_unit

Parametrised instruction prefetch unit for the next-generation spcpu core. It replaces the core's one-halfword-at-a-time instruction load states. It streams halfwords from memory into a small queue and assembles 16-bit and 32-bit instructions, presenting them to the decode/execute stage over a valid/ready handshake. It sits between the core's memory port and its instruction decoders, and is flushed by the core on any PC change (branch, call, or a non-branch write to the PC pair).

## Interface

Parameters:
- ADDR_WIDTH, 16, byte address width; addresses wrap mod 2^ADDR_WIDTH
- HW_WIDTH, 16, instruction halfword width
- QUEUE_DEPTH, 4, halfword queue entries; power of 2, at least 2
- RESET_PC, 0, fetch address after reset; bit 0 must be 0
- LONG_PREFIX_W, 3, number of top halfword bits that mark a 32-bit instruction
- LONG_PREFIX, 3'b111, prefix value marking the first halfword of a 32-bit instruction

Ports:
- clk  in  1  sole clock; all state updates on posedge
- reset  in  1  synchronous, active-low; reset == 0 at a posedge resets the block
- fetch_en  in  1  level; permits memory requests
- mem_req  out  1  read request valid
- mem_addr  out  ADDR_WIDTH  halfword-aligned read address
- mem_ack  in  1  memory accepts request; mem_rdata valid in the same cycle
- mem_rdata  in  HW_WIDTH  read data
- redirect  in  1  flush and restart fetch
- redirect_pc  in  ADDR_WIDTH  new fetch address; bit 0 ignored
- instr_valid  out  1  a complete instruction is at the queue head
- instr_ready  in  1  consumer accepts the instruction
- instr_hi  out  HW_WIDTH  first (or only) halfword
- instr_lo  out  HW_WIDTH  second halfword; 0 for 16-bit instructions
- instr_is_32  out  1  head instruction is 32-bit
- instr_pc  out  ADDR_WIDTH  address of instr_hi

## Operation

- Queue: circular buffer of QUEUE_DEPTH halfwords. Each entry has its address stored alongside it. Read pointer rd, write pointer wr, and count (width clog2(QUEUE_DEPTH)+1).
- A memory transfer occurs when mem_req && mem_ack. On a transfer:
  - mem_rdata and mem_addr are written at wr.
  - fetch_addr advances by 2, wrapping at 2^ADDR_WIDTH.
- The head is long when head[HW_WIDTH-1 -: LONG_PREFIX_W] == LONG_PREFIX.
- instr_valid = (count >= 1 && !long) || (count >= 2 && long).
- For a long head: instr_lo = entry rd+1 and instr_is_32 = 1.
- A pop occurs when instr_valid && instr_ready. It removes 1 or 2 entries.
- Push and pop may occur in the same cycle:
  - count_next = count + push - popped.
  - A push is permitted when count < QUEUE_DEPTH at the start of the cycle. The pop only frees slots for later cycles.
- Fetch FSM:
  - ST_IDLE: mem_req = 0. Go to ST_FETCH when fetch_en == 1.
  - ST_FETCH: mem_req = (count < QUEUE_DEPTH). Go to ST_FULL when count_next == QUEUE_DEPTH. Go to ST_IDLE when fetch_en == 0.
  - ST_FULL: mem_req = 0. Go to ST_FETCH when count_next < QUEUE_DEPTH, or to ST_IDLE when fetch_en == 0.
- Redirect has priority over everything. In a redirect cycle:
  - The queue is cleared (rd = wr = count = 0).
  - fetch_addr is set to {redirect_pc[ADDR_WIDTH-1:1], 1'b0}.
  - Any mem_ack data in that cycle is discarded.
  - An instr_valid && instr_ready handshake in that cycle is void; the consumer must not treat it as accepted.
  - The FSM goes to ST_FETCH if fetch_en == 1, otherwise ST_IDLE.
- A long instruction whose second halfword is not yet fetched stays at the head with instr_valid = 0. It is never split across a redirect.
- If a long first halfword sits at the last free slot, fetching continues normally. Because QUEUE_DEPTH >= 2, both halves always fit.

## Timing

- Reset values:
  - mem_req = 0, mem_addr = RESET_PC.
  - instr_valid = 0, instr_hi = instr_lo = 0, instr_is_32 = 0, instr_pc = RESET_PC.
  - FSM in ST_IDLE, count = 0.
- Reset asserted mid-operation discards the queue and any in-flight handshake at that edge.
- mem_req and mem_addr are functions of registered state only. They never depend combinationally on mem_ack.
- mem_addr is held stable while mem_req == 1 && mem_ack == 0.
- Fill latency: a halfword transferred at edge t can produce instr_valid in cycle t+1.
  - With fetch_en == 1 from reset release and mem_ack tied high, the first 16-bit instruction is valid 2 cycles after reset deasserts (one IDLE→FETCH edge, one transfer edge).
- Throughput: one halfword per cycle with mem_ack high. A 16-bit instruction can be sustained every cycle.
- After redirect at edge t: mem_req = 1 in cycle t+1 at the new address. The first new instruction is valid no earlier than t+2.

## Test plan

- Reset → redirect, normal fetch:
  - Stimulus: reset low for 2 cycles, fetch_en = 1, mem_ack = 1, memory holds 0x1234 at 0 and 0x5678 at 2, instr_ready = 1.
  - Required: mem_addr sequence 0, 2, 4. Instructions {0x1234, pc 0} then {0x5678, pc 2}, with instr_lo = 0 and instr_is_32 = 0.
- 32-bit assembly:
  - Stimulus: memory at 0 holds 0xE001 (long prefix) and 0xBEEF at 2.
  - Required: a single instruction with instr_hi = 0xE001, instr_lo = 0xBEEF, instr_is_32 = 1, instr_pc = 0. instr_valid stays 0 until 0xBEEF is queued.
- Full queue:
  - Stimulus: instr_ready = 0, mem_ack = 1.
  - Required: exactly QUEUE_DEPTH transfers, then mem_req = 0 (ST_FULL). One pop of a 16-bit instruction → mem_req = 1 the next cycle.
- Redirect collision:
  - Stimulus: redirect = 1 with redirect_pc = 0x0101 in the same cycle as mem_ack = 1 and a pop.
  - Required: queue empty, ack data dropped. Next mem_addr = 0x0100, first instr_pc = 0x0100.
- Wrap and stall:
  - Stimulus: redirect to 0xFFFE with 16-bit instructions; random mem_ack gaps.
  - Required: mem_addr sequence 0xFFFE, 0x0000, 0x0002. mem_addr stable during every gap, no lost or duplicated halfwords.
- fetch_en low mid-stream:
  - Required: mem_req drops the next cycle, queued instructions still drain, and fetch resumes at the saved address when fetch_en returns to 1.
